// File: rtl/brush_overlay.sv
// Brush cursor overlay: composites a square/cross/diamond/outline brush onto the framebuffer
// stream with a 2-cycle pipeline. Define BRUSH_BLINK_EN to add the frame-counted blink phase.
module brush_overlay #(
    parameter int         HPOS_WIDTH   = 10,
    parameter int         VPOS_WIDTH   = 10,
    parameter int         SIZE_WIDTH   = 4,
    parameter int         MAX_SIZE     = 15,
    parameter logic [2:0] BRUSH_COLOR  = 3'b101,
    parameter int         BLINK_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  display_on,
    input  logic                  vsync_start,
    input  logic [HPOS_WIDTH-1:0] hpos,
    input  logic [VPOS_WIDTH-1:0] vpos,
    input  logic [HPOS_WIDTH-1:0] cursor_xpos,
    input  logic [VPOS_WIDTH-1:0] cursor_ypos,
    input  logic [SIZE_WIDTH-1:0] brush_size,
    input  logic [1:0]            brush_shape,
    input  logic [2:0]            fb_rgb,
    output logic [2:0]            rgb,
    output logic                  hit
);

    localparam int DW = ((HPOS_WIDTH > VPOS_WIDTH) ? HPOS_WIDTH : VPOS_WIDTH) + 2;

    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_blink_frames_range
        $error("brush_overlay: BLINK_FRAMES must be in 1..255");
    end

    logic [HPOS_WIDTH-1:0] shadow_x;
    logic [VPOS_WIDTH-1:0] shadow_y;
    logic [SIZE_WIDTH-1:0] shadow_size;
    logic [1:0]            shadow_shape;

    // Brush parameters only move during vertical blank so a frame never shows two positions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_size  <= '0;
            shadow_shape <= '0;
        end else if (vsync_start) begin
            shadow_x     <= cursor_xpos;
            shadow_y     <= cursor_ypos;
            shadow_size  <= brush_size;
            shadow_shape <= brush_shape;
        end
    end

`ifdef BRUSH_BLINK_EN
    logic [7:0] blink_count;
    logic       blink_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_count <= '0;
            blink_phase <= 1'b0;
        end else if (vsync_start) begin
            if (blink_count == 8'(BLINK_FRAMES - 1)) begin
                blink_count <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_count <= blink_count + 8'd1;
            end
        end
    end
`endif

    logic [HPOS_WIDTH:0]   dx_next;
    logic [VPOS_WIDTH:0]   dy_next;
    logic [SIZE_WIDTH-1:0] size_next;

    // Distances are taken one bit wider so the far side of the screen stays far away.
    always_comb begin
        dx_next   = '0;
        dy_next   = '0;
        size_next = shadow_size;
        if (hpos >= shadow_x) dx_next = {1'b0, hpos} - {1'b0, shadow_x};
        else                  dx_next = {1'b0, shadow_x} - {1'b0, hpos};
        if (vpos >= shadow_y) dy_next = {1'b0, vpos} - {1'b0, shadow_y};
        else                  dy_next = {1'b0, shadow_y} - {1'b0, vpos};
        if (int'(shadow_size) > MAX_SIZE) size_next = SIZE_WIDTH'(MAX_SIZE);
    end

    logic [HPOS_WIDTH:0]   s1_dx;
    logic [VPOS_WIDTH:0]   s1_dy;
    logic [SIZE_WIDTH-1:0] s1_size;
    logic [1:0]            s1_shape;
    logic [2:0]            s1_fb;
    logic                  s1_display;
`ifdef BRUSH_BLINK_EN
    logic                  s1_phase;
`endif

    // Size, shape and phase travel with each pixel so a vsync mid-pipeline stays coherent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_dx      <= '0;
            s1_dy      <= '0;
            s1_size    <= '0;
            s1_shape   <= '0;
            s1_fb      <= '0;
            s1_display <= 1'b0;
`ifdef BRUSH_BLINK_EN
            s1_phase   <= 1'b0;
`endif
        end else begin
            s1_dx      <= dx_next;
            s1_dy      <= dy_next;
            s1_size    <= size_next;
            s1_shape   <= brush_shape_sel(shadow_shape);
            s1_fb      <= fb_rgb;
            s1_display <= display_on;
`ifdef BRUSH_BLINK_EN
            s1_phase   <= blink_phase;
`endif
        end
    end

    function automatic logic [1:0] brush_shape_sel(input logic [1:0] shape);
        return shape;
    endfunction

    logic [DW-1:0] dx_e, dy_e, s_e, sum_e, max_e;
    logic          shape_hit;
    logic [2:0]    brush_rgb;
    logic [2:0]    rgb_next;

    always_comb begin
        dx_e      = DW'(s1_dx);
        dy_e      = DW'(s1_dy);
        s_e       = DW'(s1_size);
        sum_e     = dx_e + dy_e;
        max_e     = (dx_e > dy_e) ? dx_e : dy_e;
        shape_hit = 1'b0;
        case (s1_shape)
            2'd0:    shape_hit = (dx_e <= s_e) && (dy_e <= s_e);
            2'd1:    shape_hit = ((dx_e == '0) && (dy_e <= s_e)) || ((dy_e == '0) && (dx_e <= s_e));
            2'd2:    shape_hit = (sum_e <= s_e);
            default: shape_hit = (max_e == s_e);
        endcase
`ifdef BRUSH_BLINK_EN
        brush_rgb = s1_phase ? ~s1_fb : BRUSH_COLOR;
`else
        brush_rgb = BRUSH_COLOR;
`endif
        rgb_next = 3'b000;
        if (s1_display) rgb_next = shape_hit ? brush_rgb : s1_fb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= '0;
            hit <= 1'b0;
        end else begin
            rgb <= rgb_next;
            hit <= s1_display & shape_hit;
        end
    end

endmodule

// File: doc/brush_overlay.md
BRUSH_OVERLAY -- requirements
Module: brush_overlay

Interface
REQ-001 SHALL have parameter HPOS_WIDTH, default 10, the width of the horizontal coordinate.
REQ-002 SHALL have parameter VPOS_WIDTH, default 10, the width of the vertical coordinate.
REQ-003 SHALL have parameter SIZE_WIDTH, default 4, the width of brush_size.
REQ-004 SHALL have parameter MAX_SIZE, default 15, the clamp applied to the brush half-size.
REQ-005 SHALL have parameter BRUSH_COLOR, default 3'b101, the brush pixel colour.
REQ-006 SHALL have parameter BLINK_FRAMES, default 16, the number of frames per blink phase; legal range 1..255.
REQ-007 SHALL have ports as follows.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- display_on  in  1  the current pixel is visible.
- vsync_start  in  1  one-cycle pulse at the start of vertical blank.
- hpos  in  HPOS_WIDTH  current pixel x.
- vpos  in  VPOS_WIDTH  current pixel y.
- cursor_xpos  in  HPOS_WIDTH  brush centre x.
- cursor_ypos  in  VPOS_WIDTH  brush centre y.
- brush_size  in  SIZE_WIDTH  brush half-size.
- brush_shape  in  2  brush shape: 0 square, 1 cross, 2 diamond, 3 outline.
- fb_rgb  in  3  framebuffer pixel.
- rgb  out  3  composited pixel.
- hit  out  1  the output pixel lies inside the brush.

Function
REQ-008 SHALL capture cursor_xpos, cursor_ypos, brush_size and brush_shape into shadow registers only in a cycle where vsync_start=1; changes at any other time SHALL have no effect until the next pulse (no tearing).
REQ-009 SHALL compute the effective size s = min(shadow size, MAX_SIZE).
REQ-010 Stage 1 SHALL register dx=|hpos-cx| and dy=|vpos-cy|, computed at width+1 with no modular wrap, together with the delayed fb_rgb and display_on.
REQ-011 Stage 2 SHALL register rgb and hit; latency from hpos/vpos/fb_rgb/display_on to rgb/hit is exactly 2 cycles, at a throughput of 1 pixel per cycle.
REQ-012 Hit conditions SHALL be as follows.
- Square: dx<=s and dy<=s.
- Cross: (dx==0 and dy<=s) or (dy==0 and dx<=s).
- Diamond: dx+dy<=s.
- Outline: max(dx,dy)==s.
REQ-013 With delayed display_on=0, SHALL output rgb=0 and hit=0.
REQ-014 With delayed display_on=1 and hit=0, SHALL output rgb equal to the delayed fb_rgb.
REQ-015 With delayed display_on=1 and hit=1, SHALL output rgb=BRUSH_COLOR, except as modified by REQ-019.
REQ-016 A cursor near a screen edge SHALL clip; pixels across the opposite edge SHALL never be hit (e.g. cx=1, s=3: hpos=1022 is a miss).
REQ-017 With s=0, square, diamond and outline SHALL hit the single centre pixel only.

Reset
REQ-018 While reset=1, and immediately on its assertion, SHALL set the following to 0: rgb, hit, all pipeline registers, the shadow cursor/size/shape, the blink counter and the blink phase. Reset asserted mid-frame SHALL discard in-flight pixels. After release, the shadow state SHALL remain 0 (brush at (0,0), size 0, square) until the first vsync_start.

Configuration
REQ-019 With macro BRUSH_BLINK_EN defined, SHALL implement the following.
- An 8-bit frame counter increments on each vsync_start.
- When the counter reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles, in the same cycle.
- While phase=1, hit pixels SHALL output ~fb_rgb (delayed) instead of BRUSH_COLOR.
REQ-020 Without BRUSH_BLINK_EN, SHALL omit the counter and phase logic, and hit pixels SHALL always output BRUSH_COLOR.

Verification
REQ-021 Square test: pulse vsync_start with cursor (100,50), size 3, shape 0, fb_rgb=3'b010, display_on=1.
- (103,50) -> rgb=3'b101 and hit=1 exactly 2 cycles later.
- (104,50) -> rgb=3'b010 and hit=0.
REQ-022 Shadow test: change cursor to (200,50) with no vsync_start.
- (103,50) -> still hit.
- After vsync_start, (103,50) -> miss and (200,50) -> hit.
REQ-023 Edge and clamp tests:
- Cursor (1,1), s=3, hpos=1022 -> hit=0.
- MAX_SIZE=8, brush_size=15: dx=8 -> hit; dx=9 -> miss.
REQ-024 Shape tests with s=3:
- Diamond: (dx,dy)=(1,2) -> hit; (2,2) -> miss.
- Outline: (3,1) -> hit; (2,2) -> miss.
- Cross: (0,3) -> hit; (1,1) -> miss.
REQ-025 Blink and reset tests:
- With BRUSH_BLINK_EN and BLINK_FRAMES=2, after 2 vsync_start pulses a hit pixel with fb_rgb=3'b010 -> rgb=3'b101.
- Reset asserted mid-line -> rgb=0 and hit=0 immediately.
